csr_reg_file: RTL and testbench
===============================

CSR_REG_FILE -- requirements
Module: csr_reg_file

Interface
REQ-001 SHALL have parameter Hartid, default -1, hart ID returned by mhartid; elaboration SHALL fail if left at -1.
REQ-002 SHALL have clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_i  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have priv_lvl_o  output  priv_lvl_e (2)  current privilege level.
REQ-005 SHALL have csr_ctrl_i  input  csr_ctrl_s  decode-stage CSR request: is_rd (CSR instruction reads) and is_wr (instruction will write).
REQ-006 SHALL have is_ill_acc_o  output  1  decode-stage access at raddr_i is illegal.
REQ-007 SHALL have raddr_i  input  12  decode-stage CSR read address.
REQ-008 SHALL have rdata_o  output  32  read data for raddr_i.
REQ-009 SHALL have we_i, waddr_i, wdata_i  input  1/12/32  commit-stage CSR write enable, address and data.
REQ-010 SHALL have exc_i  input  exc_s  commit-stage exception: valid, cause[31:0], tval[31:0].
REQ-011 SHALL have pc_i  input  32  PC of the committing instruction.
REQ-012 SHALL have tvec_o  output  32  trap target PC.
REQ-013 SHALL have mret_i  input  1  commit-stage MRET.
REQ-014 SHALL have eret_o  output  1  asserted when trap return redirects fetch.
REQ-015 SHALL have epc_o  output  32  trap return target.

Function
REQ-016 SHALL implement CSRs: mvendorid, marchid, mimpid (0, RO), mhartid (Hartid, RO), misa (RO, 0x40100100: RV32I plus U), mstatus (MIE bit 3, MPIE bit 7, MPP bits 12:11; other bits read 0), mtvec, mscratch, mepc, mcause, mtval, mie, mip (reads 0), mcycle/mcycleh, cycle/cycleh (RO shadows).
REQ-017 rdata_o SHALL be a combinational read of raddr_i; unimplemented or illegal addresses read 0; a write in the same cycle is not bypassed.
REQ-018 is_ill_acc_o SHALL be 1 when csr_ctrl_i.is_rd or is_wr is set and the address is unimplemented, priv_lvl_o < raddr_i[9:8], or is_wr is set with raddr_i[11:10]==2'b11; otherwise 0.
REQ-019 When we_i=1 and exc_i.valid=0, the CSR at waddr_i SHALL load wdata_i at the next edge, with WARL masking: mtvec[1:0] forced 00, mepc[1:0] forced 00, MPP written 00 or 11 only (other values keep the old MPP); writes to RO or unimplemented addresses are ignored.
REQ-020 mcycle (64-bit) SHALL increment every cycle; a write to mcycle or mcycleh replaces that half, and the increment is skipped in the write cycle.
REQ-021 On exc_i.valid=1: mepc<=pc_i, mcause<=exc_i.cause, mtval<=exc_i.tval, MPIE<=MIE, MIE<=0, MPP<=priv, priv<=M; any concurrent we_i write SHALL be dropped.
REQ-022 tvec_o SHALL be combinational {mtvec[31:2],2'b00} (direct mode only).
REQ-023 On mret_i=1 with exc_i.valid=0: priv<=MPP, MIE<=MPIE, MPIE<=1, MPP<=U; eret_o = mret_i && !exc_i.valid, combinational; epc_o = mepc, combinational.
REQ-024 Exception SHALL take priority over mret_i in the same cycle.

Reset
REQ-025 While rst_i=1, state SHALL be forced asynchronously: priv=M (2'b11), mstatus=0, mtvec=0, mscratch=0, mepc=0, mcause=0, mtval=0, mie=0, mcycle=0.
REQ-026 Outputs after reset: priv_lvl_o=3, tvec_o=0, epc_o=0, eret_o=mret_i && !exc_i.valid.

Structure
REQ-027 priv_lvl_e (U=0, S=1, M=3), csr_ctrl_s, exc_s, XLEN=32, CSR address constants, CAUSE_* codes and RESET_VECTOR SHALL reside in the shared package rei_pkg.
REQ-028 The block SHALL be a single module with no sub-modules.

Verification
REQ-029 Reset, then read 0xF14 with is_rd=1 -> rdata_o=Hartid, is_ill_acc_o=0, priv_lvl_o=3.
REQ-030 Write mtvec=0x80000103 -> tvec_o=0x80000100; read mtvec -> 0x80000100.
REQ-031 Set MIE=1, then exc_i={1,2,0x13}, pc_i=0x80000040 -> mepc=0x80000040, mcause=2, mtval=0x13, mstatus=0x1880, priv=3.
REQ-032 Write mstatus MPP=00, MPIE=1, mepc=0x200, then mret_i=1 -> eret_o=1, epc_o=0x200; next cycle priv_lvl_o=0, MIE=1.
REQ-033 At priv=U, read 0x300 -> is_ill_acc_o=1; at priv=M, is_wr=1 at 0xF11 -> is_ill_acc_o=1; read 0x7FF -> is_ill_acc_o=1.
REQ-034 we_i=1 to mscratch concurrent with exc_i.valid=1 -> mscratch unchanged; assert rst_i mid-run -> all CSRs return to reset values without a clock edge.

Source files
------------

// File: rtl/rei_pkg.sv
// Shared core definitions: privilege levels, CSR request/exception structs,
// CSR addresses, trap cause codes and the reset vector.
package rei_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_lvl_e;

  typedef struct packed {
    logic is_rd;
    logic is_wr;
  } csr_ctrl_s;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exc_s;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [XLEN-1:0] CAUSE_INSN_MISALIGNED = 32'd0;
  localparam logic [XLEN-1:0] CAUSE_INSN_FAULT      = 32'd1;
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL_INSN    = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT      = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_LOAD_MISALIGNED = 32'd4;
  localparam logic [XLEN-1:0] CAUSE_LOAD_FAULT      = 32'd5;
  localparam logic [XLEN-1:0] CAUSE_STORE_MISALIGNED= 32'd6;
  localparam logic [XLEN-1:0] CAUSE_STORE_FAULT     = 32'd7;
  localparam logic [XLEN-1:0] CAUSE_ECALL_U         = 32'd8;
  localparam logic [XLEN-1:0] CAUSE_ECALL_M         = 32'd11;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;

  // RV32I with the U extension, MXL=1.
  localparam logic [XLEN-1:0] MISA_VALUE = 32'h4010_0100;

endpackage

// File: rtl/csr_reg_file.sv
// Machine-mode CSR file: decode-stage combinational reads and access checks,
// commit-stage writes, trap entry and MRET handling, free-running mcycle.
module csr_reg_file
  import rei_pkg::*;
#(
  parameter int Hartid = -1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output priv_lvl_e         priv_lvl_o,
  input  csr_ctrl_s         csr_ctrl_i,
  output logic              is_ill_acc_o,
  input  logic [11:0]       raddr_i,
  output logic [XLEN-1:0]   rdata_o,
  input  logic              we_i,
  input  logic [11:0]       waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  exc_s              exc_i,
  input  logic [XLEN-1:0]   pc_i,
  output logic [XLEN-1:0]   tvec_o,
  input  logic              mret_i,
  output logic              eret_o,
  output logic [XLEN-1:0]   epc_o
);

  if (Hartid == -1) begin : g_hartid_unset
    $error("csr_reg_file: Hartid must be set");
  end

  priv_lvl_e         priv_lvl;
  logic              st_mie;
  logic              st_mpie;
  logic [1:0]        st_mpp;
  logic [XLEN-1:2]   mtvec_q;
  logic [XLEN-1:0]   mscratch_q;
  logic [XLEN-1:2]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtval_q;
  logic [XLEN-1:0]   mie_q;
  logic [63:0]       mcycle_q;

  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   rd_val;
  logic              rd_impl;
  logic              priv_ok;
  logic              csr_wr;

  assign mstatus_val = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
  assign csr_wr      = we_i && !exc_i.valid;

  always_comb begin
    rd_impl = 1'b1;
    rd_val  = '0;
    unique case (raddr_i)
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = '0;
      CSR_MHARTID:                 rd_val = 32'(Hartid);
      CSR_MISA:                    rd_val = MISA_VALUE;
      CSR_MSTATUS:                 rd_val = mstatus_val;
      CSR_MTVEC:                   rd_val = {mtvec_q, 2'b00};
      CSR_MSCRATCH:                rd_val = mscratch_q;
      CSR_MEPC:                    rd_val = {mepc_q, 2'b00};
      CSR_MCAUSE:                  rd_val = mcause_q;
      CSR_MTVAL:                   rd_val = mtval_q;
      CSR_MIE:                     rd_val = mie_q;
      CSR_MIP:                     rd_val = '0;
      CSR_MCYCLE, CSR_CYCLE:       rd_val = mcycle_q[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:     rd_val = mcycle_q[63:32];
      default:                     rd_impl = 1'b0;
    endcase
  end

  // Address bits [9:8] encode the lowest privilege allowed to touch the CSR.
  assign priv_ok      = priv_lvl >= raddr_i[9:8];
  assign rdata_o      = (rd_impl && priv_ok) ? rd_val : '0;
  assign is_ill_acc_o = (csr_ctrl_i.is_rd || csr_ctrl_i.is_wr) &&
                        (!rd_impl || !priv_ok ||
                         (csr_ctrl_i.is_wr && raddr_i[11:10] == 2'b11));

  assign priv_lvl_o = priv_lvl;
  assign tvec_o     = {mtvec_q, 2'b00};
  assign epc_o      = {mepc_q, 2'b00};
  assign eret_o     = mret_i && !exc_i.valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      priv_lvl   <= PRIV_M;
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      st_mpp     <= 2'b00;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mie_q      <= '0;
      mcycle_q   <= '0;
    end else begin
      // A software write to either half suppresses that cycle's increment.
      if (csr_wr && waddr_i == CSR_MCYCLE)
        mcycle_q[31:0] <= wdata_i;
      else if (csr_wr && waddr_i == CSR_MCYCLEH)
        mcycle_q[63:32] <= wdata_i;
      else
        mcycle_q <= mcycle_q + 64'd1;

      if (exc_i.valid) begin
        mepc_q   <= pc_i[XLEN-1:2];
        mcause_q <= exc_i.cause;
        mtval_q  <= exc_i.tval;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
        st_mpp   <= priv_lvl;
        priv_lvl <= PRIV_M;
      end else begin
        if (we_i) begin
          unique case (waddr_i)
            CSR_MSTATUS: begin
              st_mie  <= wdata_i[3];
              st_mpie <= wdata_i[7];
              if (wdata_i[12:11] == 2'b00 || wdata_i[12:11] == 2'b11)
                st_mpp <= wdata_i[12:11];
            end
            CSR_MTVEC:    mtvec_q    <= wdata_i[XLEN-1:2];
            CSR_MSCRATCH: mscratch_q <= wdata_i;
            CSR_MEPC:     mepc_q     <= wdata_i[XLEN-1:2];
            CSR_MCAUSE:   mcause_q   <= wdata_i;
            CSR_MTVAL:    mtval_q    <= wdata_i;
            CSR_MIE:      mie_q      <= wdata_i;
            default: ;
          endcase
        end
        // MRET updates land after any same-cycle CSR write so they win.
        if (mret_i) begin
          priv_lvl <= priv_lvl_e'(st_mpp);
          st_mie   <= st_mpie;
          st_mpie  <= 1'b1;
          st_mpp   <= PRIV_U;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_reg_file.sv
// Self-checking bench for csr_reg_file: expected read results are queued when
// a read is driven and popped when the combinational result is sampled.
module tb_csr_reg_file;
  import rei_pkg::*;

  localparam int HART = 5;

  logic        clk = 1'b0;
  logic        rst;
  priv_lvl_e   priv_lvl;
  csr_ctrl_s   csr_ctrl;
  logic        is_ill_acc;
  logic [11:0] raddr;
  logic [31:0] rdata;
  logic        we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  exc_s        exc;
  logic [31:0] pc;
  logic [31:0] tvec;
  logic        mret;
  logic        eret;
  logic [31:0] epc;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  csr_reg_file #(.Hartid(HART)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .priv_lvl_o   (priv_lvl),
    .csr_ctrl_i   (csr_ctrl),
    .is_ill_acc_o (is_ill_acc),
    .raddr_i      (raddr),
    .rdata_o      (rdata),
    .we_i         (we),
    .waddr_i      (waddr),
    .wdata_i      (wdata),
    .exc_i        (exc),
    .pc_i         (pc),
    .tvec_o       (tvec),
    .mret_i       (mret),
    .eret_o       (eret),
    .epc_o        (epc)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Combinational read; callers keep at most three reads per low clock phase.
  task automatic do_read(input logic [11:0] addr, input logic [31:0] exp_data,
                         input logic exp_ill, input logic wr_flag);
    raddr          = addr;
    csr_ctrl.is_rd = 1'b1;
    csr_ctrl.is_wr = wr_flag;
    exp_q.push_back(exp_data);
    exp_q.push_back({31'b0, exp_ill});
    #1;
    check($sformatf("rdata_%03h", addr), rdata, exp_q.pop_front());
    check($sformatf("ill_%03h", addr), {31'b0, is_ill_acc}, exp_q.pop_front());
    csr_ctrl = '0;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data);
    waddr = addr;
    wdata = data;
    we    = 1'b1;
    @(negedge clk);
    we    = 1'b0;
  endtask

  task automatic do_exc(input logic [31:0] cause, input logic [31:0] tval,
                        input logic [31:0] pcv);
    exc.valid = 1'b1;
    exc.cause = cause;
    exc.tval  = tval;
    pc        = pcv;
    @(negedge clk);
    exc = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_priv(input logic [1:0] exp);
    check("priv", {30'b0, priv_lvl}, {30'b0, exp});
  endtask

  logic [11:0] rnd_addr [5];
  logic [11:0] a;
  logic [31:0] d;
  logic [31:0] e;

  initial begin
    rst = 1'b1; csr_ctrl = '0; raddr = '0; we = 1'b0; waddr = '0; wdata = '0;
    exc = '0; pc = '0; mret = 1'b0;
    rnd_addr = '{CSR_MSCRATCH, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MTVAL};

    // reset state
    @(negedge clk);
    check_priv(2'b11);
    check("tvec_rst", tvec, 32'h0);
    check("epc_rst", epc, 32'h0);
    check("eret_rst", {31'b0, eret}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // hart id, first cycle count
    do_read(CSR_MHARTID, HART, 1'b0, 1'b0);
    do_read(CSR_CYCLE, 32'd1, 1'b0, 1'b0);
    check_priv(2'b11);

    // mtvec WARL
    do_write(CSR_MTVEC, 32'h8000_0103);
    check("tvec", tvec, 32'h8000_0100);
    do_read(CSR_MTVEC, 32'h8000_0100, 1'b0, 1'b0);

    // trap entry
    do_write(CSR_MSTATUS, 32'h8);
    do_read(CSR_MSTATUS, 32'h8, 1'b0, 1'b0);
    do_exc(CAUSE_ILLEGAL_INSN, 32'h13, 32'h8000_0040);
    check_priv(2'b11);
    do_read(CSR_MEPC, 32'h8000_0040, 1'b0, 1'b0);
    do_read(CSR_MCAUSE, 32'd2, 1'b0, 1'b0);
    do_read(CSR_MTVAL, 32'h13, 1'b0, 1'b0);
    idle(1);
    do_read(CSR_MSTATUS, 32'h1880, 1'b0, 1'b0);

    // mret to U
    do_write(CSR_MSTATUS, 32'h80);
    do_write(CSR_MEPC, 32'h200);
    mret = 1'b1;
    #1;
    check("eret", {31'b0, eret}, 32'h1);
    check("epc", epc, 32'h200);
    @(negedge clk);
    mret = 1'b0;
    check_priv(2'b00);

    // U-mode access to M CSRs is illegal and reads 0
    do_read(CSR_MSTATUS, 32'h0, 1'b1, 1'b0);
    do_read(CSR_MSCRATCH, 32'h0, 1'b1, 1'b0);
    do_exc(CAUSE_ECALL_U, 32'h0, 32'h100);
    check_priv(2'b11);
    // MPIE captures the MIE restored by mret; MPP captures U
    do_read(CSR_MSTATUS, 32'h80, 1'b0, 1'b0);
    do_read(CSR_MCAUSE, 32'd8, 1'b0, 1'b0);
    do_read(CSR_MEPC, 32'h100, 1'b0, 1'b0);
    idle(1);

    // illegal encodings at M
    do_read(CSR_MVENDORID, 32'h0, 1'b1, 1'b1);
    do_read(12'h7FF, 32'h0, 1'b1, 1'b0);
    do_read(CSR_MISA, 32'h4010_0100, 1'b0, 1'b0);
    do_write(CSR_MISA, 32'h0);
    do_read(CSR_MISA, 32'h4010_0100, 1'b0, 1'b0);
    do_write(CSR_MIP, 32'hFFFF_FFFF);
    do_read(CSR_MIP, 32'h0, 1'b0, 1'b0);

    // WARL on mepc and MPP
    do_write(CSR_MEPC, 32'h203);
    do_read(CSR_MEPC, 32'h200, 1'b0, 1'b0);
    do_write(CSR_MSTATUS, 32'h1008);
    do_read(CSR_MSTATUS, 32'h8, 1'b0, 1'b0);
    do_write(CSR_MSTATUS, 32'h1800);
    do_read(CSR_MSTATUS, 32'h1800, 1'b0, 1'b0);

    // exception beats concurrent write and mret
    do_write(CSR_MSCRATCH, 32'hAAAA_5555);
    we = 1'b1; waddr = CSR_MSCRATCH; wdata = 32'h1234;
    mret = 1'b1;
    exc.valid = 1'b1; exc.cause = CAUSE_STORE_FAULT; exc.tval = 32'h99; pc = 32'h300;
    #1;
    check("eret_exc", {31'b0, eret}, 32'h0);
    @(negedge clk);
    we = 1'b0; mret = 1'b0; exc = '0;
    check_priv(2'b11);
    do_read(CSR_MSCRATCH, 32'hAAAA_5555, 1'b0, 1'b0);
    do_read(CSR_MSTATUS, 32'h1800, 1'b0, 1'b0);
    do_read(CSR_MEPC, 32'h300, 1'b0, 1'b0);
    idle(1);

    // random writes with WARL model
    for (int i = 0; i < 8; i++) begin
      a = rnd_addr[$urandom_range(0, 4)];
      d = $urandom;
      e = (a == CSR_MTVEC || a == CSR_MEPC) ? (d & 32'hFFFF_FFFC) : d;
      do_write(a, d);
      do_read(a, e, 1'b0, 1'b0);
    end
    idle(1);

    // mcycle write, carry and increment
    do_write(CSR_MCYCLEH, 32'h5);
    do_write(CSR_MCYCLE, 32'hFFFF_FFFF);
    do_read(CSR_MCYCLE, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_read(CSR_CYCLEH, 32'h5, 1'b0, 1'b0);
    idle(1);
    do_read(CSR_CYCLE, 32'h0, 1'b0, 1'b0);
    do_read(CSR_CYCLEH, 32'h6, 1'b0, 1'b0);
    do_read(CSR_MCYCLEH, 32'h6, 1'b0, 1'b0);
    idle(3);
    do_read(CSR_MCYCLE, 32'h3, 1'b0, 1'b0);
    idle(1);

    // asynchronous reset from U mode with live state
    do_write(CSR_MTVEC, 32'h400);
    do_write(CSR_MSTATUS, 32'h0);
    do_write(CSR_MEPC, 32'h80);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    check_priv(2'b00);
    rst = 1'b1;
    #1;
    check_priv(2'b11);
    check("tvec_arst", tvec, 32'h0);
    check("epc_arst", epc, 32'h0);
    do_read(CSR_MSCRATCH, 32'h0, 1'b0, 1'b0);
    do_read(CSR_MSTATUS, 32'h0, 1'b0, 1'b0);
    do_read(CSR_MCYCLE, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    do_read(CSR_MCAUSE, 32'h0, 1'b0, 1'b0);
    do_read(CSR_MTVAL, 32'h0, 1'b0, 1'b0);
    do_read(CSR_MIE, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    do_read(CSR_MCYCLE, 32'h2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
